// File: rtl/edge_pulse_gen_pkg.sv
// Shared types and constants for the edge_pulse_gen pulse-train generator.
// The LFSR step function is only exercised when EDGE_PULSE_GEN_LFSR_EN is defined.
package edge_pulse_gen_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HIGH = 3'd1,
        LOW  = 3'd2,
        RAND = 3'd3,
        FIN  = 3'd4
    } state_e;

    localparam int              LFSR_W    = 16;
    // Taps for x^16 + x^14 + x^13 + x^11 + 1 (bits 15, 13, 12, 10)
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/edge_pulse_gen_lfsr.sv
// 16-bit Fibonacci LFSR that advances only while enabled.
// o_bit is the bit the register will hold after this cycle, so a caller can register it directly.
module edge_pulse_gen_lfsr
    import edge_pulse_gen_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    output logic o_bit
);

    logic [LFSR_W-1:0] r_lfsr;
    logic [LFSR_W-1:0] w_lfsr_next;

    always_comb begin
        w_lfsr_next = i_en ? lfsr_step(r_lfsr) : r_lfsr;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= w_lfsr_next;
        end
    end

    assign o_bit = w_lfsr_next[0];

endmodule

// File: rtl/edge_pulse_gen.sv
// Programmable pulse-train generator with a registered rising-edge strobe.
// Define EDGE_PULSE_GEN_LFSR_EN to add the pseudo-random (RAND) mode.
module edge_pulse_gen
    import edge_pulse_gen_pkg::*;
#(
    parameter int              CW        = 8,
    parameter int              NW        = 8,
    parameter logic [15:0]     LFSR_SEED = 16'hACE1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [CW-1:0] cfg_high,
    input  logic [CW-1:0] cfg_low,
    input  logic [NW-1:0] cfg_count,
    input  logic          cfg_rand,
    input  logic          stop,
    output logic          a_out,
    output logic          rose_o,
    output logic          busy,
    output logic          done,
    output logic [NW-1:0] pulses_sent
);

    state_e        r_state, w_state_next;
    logic [CW-1:0] r_phase, w_phase_next;
    logic [CW-1:0] r_high, w_high_next;
    logic [CW-1:0] r_low, w_low_next;
    logic [NW-1:0] r_count, w_count_next;
    logic [NW-1:0] r_pulses, w_pulses_next;
    logic          r_a_out, w_a_out_next;
    logic          r_rose, w_rose_next;
    logic          r_done, w_done_next;
    logic          w_accept;
    logic          w_lfsr_bit;
    logic [CW-1:0] w_cfg_high_m1, w_high_m1, w_low_m1;

    // A zero phase length behaves as one cycle
    assign w_cfg_high_m1 = (cfg_high == '0) ? '0 : cfg_high - 1'b1;
    assign w_high_m1     = (r_high == '0)   ? '0 : r_high - 1'b1;
    assign w_low_m1      = (r_low == '0)    ? '0 : r_low - 1'b1;
    assign w_accept      = cfg_valid && (r_state == IDLE);

`ifdef EDGE_PULSE_GEN_LFSR_EN
    logic [NW-1:0] r_rand_left, w_rand_left_next;

    edge_pulse_gen_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (r_state == RAND),
        .o_bit (w_lfsr_bit)
    );
`else
    logic w_unused;
    assign w_unused   = ^{cfg_rand, LFSR_SEED};
    assign w_lfsr_bit = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_phase_next = r_phase;
        w_high_next  = r_high;
        w_low_next   = r_low;
        w_count_next = r_count;
`ifdef EDGE_PULSE_GEN_LFSR_EN
        w_rand_left_next = r_rand_left;
`endif
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_high_next  = cfg_high;
                    w_low_next   = cfg_low;
                    w_count_next = cfg_count;
                    if (cfg_count == '0) begin
                        w_state_next = FIN;
`ifdef EDGE_PULSE_GEN_LFSR_EN
                    end else if (cfg_rand) begin
                        w_state_next     = RAND;
                        w_rand_left_next = cfg_count - 1'b1;
`endif
                    end else begin
                        w_state_next = HIGH;
                        w_phase_next = w_cfg_high_m1;
                    end
                end
            end
            HIGH: begin
                if (stop) begin
                    w_state_next = FIN;
                end else if (r_phase != '0) begin
                    w_phase_next = r_phase - 1'b1;
                end else if (r_pulses >= r_count) begin
                    // Last pulse: no trailing low phase
                    w_state_next = FIN;
                end else begin
                    w_state_next = LOW;
                    w_phase_next = w_low_m1;
                end
            end
            LOW: begin
                if (stop) begin
                    w_state_next = FIN;
                end else if (r_phase != '0) begin
                    w_phase_next = r_phase - 1'b1;
                end else begin
                    w_state_next = HIGH;
                    w_phase_next = w_high_m1;
                end
            end
`ifdef EDGE_PULSE_GEN_LFSR_EN
            RAND: begin
                if (stop || (r_rand_left == '0)) begin
                    w_state_next = FIN;
                end else begin
                    w_rand_left_next = r_rand_left - 1'b1;
                end
            end
`endif
            FIN:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase

        w_a_out_next = (w_state_next == HIGH) || ((w_state_next == RAND) && w_lfsr_bit);
        w_rose_next  = w_a_out_next && !r_a_out;
        w_done_next  = (w_state_next == FIN);

        if (w_accept) begin
            w_pulses_next = {{(NW-1){1'b0}}, w_rose_next};
        end else if (w_rose_next && (r_pulses != '1)) begin
            w_pulses_next = r_pulses + 1'b1;
        end else begin
            w_pulses_next = r_pulses;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_phase  <= '0;
            r_high   <= '0;
            r_low    <= '0;
            r_count  <= '0;
            r_pulses <= '0;
            r_a_out  <= 1'b0;
            r_rose   <= 1'b0;
            r_done   <= 1'b0;
`ifdef EDGE_PULSE_GEN_LFSR_EN
            r_rand_left <= '0;
`endif
        end else begin
            r_state  <= w_state_next;
            r_phase  <= w_phase_next;
            r_high   <= w_high_next;
            r_low    <= w_low_next;
            r_count  <= w_count_next;
            r_pulses <= w_pulses_next;
            r_a_out  <= w_a_out_next;
            r_rose   <= w_rose_next;
            r_done   <= w_done_next;
`ifdef EDGE_PULSE_GEN_LFSR_EN
            r_rand_left <= w_rand_left_next;
`endif
        end
    end

    assign cfg_ready   = (r_state == IDLE);
    assign busy        = (r_state == HIGH) || (r_state == LOW) || (r_state == RAND);
    assign a_out       = r_a_out;
    assign rose_o      = r_rose;
    assign done        = r_done;
    assign pulses_sent = r_pulses;

endmodule
